ctl_missile_player: RTL and testbench

Player-missile controller. It sits directly upstream of each en_one enemy instance and drives that block's xpos_missile, ypos_missile and on_missle inputs. On a fire-button press it launches one missile from the player ship's nose and moves it upward at a fixed rate. The missile is retired at the screen top or when an enemy reports a hit, followed by a cooldown before the next shot is allowed.

---
 rtl/game_pkg.sv | 26 ++
 rtl/sync_edge.sv | 36 +++
 rtl/ctl_missile_player.sv | 161 ++++++++++++++++
 tb/tb_ctl_missile_player.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the game datapath.
//   - Screen geometry: X_MAX, Y_MAX, Y_TOP
//   - Sprite sizes:    SHIP_W, MISSILE_W, MISSILE_H
//   - state_e:         controller FSM encoding (IDLE, FLY, COOL)
// -----------------------------------------------------------------------------
package game_pkg;

    // Screen geometry (pixels)
    localparam int X_MAX = 1023;
    localparam int Y_MAX = 767;
    localparam int Y_TOP = 0;

    // Sprite sizes (pixels)
    localparam int SHIP_W    = 64;
    localparam int MISSILE_W = 4;
    localparam int MISSILE_H = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } state_e;

endpackage : game_pkg

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous level into the pclk domain through two flops and
// emits a one-cycle pulse on each 0->1 transition of the synchronised level.
// Ports:
//   pclk     in   clock
//   rst      in   asynchronous active-high reset
//   d_async  in   asynchronous level (e.g. a debounced button)
//   pulse    out  one-cycle pulse on a synchronised rising edge
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic pclk,
    input  logic rst,
    input  logic d_async,
    output logic pulse
);

    logic meta_q;   // first synchroniser flop, may go metastable
    logic sync_q;   // second synchroniser flop, safe to use
    logic prev_q;   // delayed copy for edge detection

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule : sync_edge

// File: rtl/ctl_missile_player.sv
// -----------------------------------------------------------------------------
// ctl_missile_player
// Player missile controller. A fire-button press launches one missile from the
// ship's nose; it climbs STEP pixels every MOVE_DIV cycles until it reaches the
// top of the screen or an enemy reports a hit, then a COOLDOWN period must pass
// before the next shot is accepted.
// Parameters:
//   MOVE_DIV  pclk cycles per move step
//   STEP      pixels climbed per move step
//   COOLDOWN  pclk cycles after retirement before re-arming
// Ports:
//   pclk          in   pixel clock
//   rst           in   asynchronous active-high reset
//   fire_btn      in   debounced fire button (asynchronous)
//   xpos_player   in   ship left x
//   ypos_player   in   ship top y
//   hit           in   one-cycle collision pulse from the enemies
//   xpos_missile  out  missile left x
//   ypos_missile  out  missile top y
//   on_missile    out  missile alive
//   shots         out  launched-missile count (wraps)
// -----------------------------------------------------------------------------
module ctl_missile_player
    import game_pkg::*;
#(
    parameter int unsigned MOVE_DIV = 65000,
    parameter int unsigned STEP     = 4,
    parameter int unsigned COOLDOWN = 3250000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        fire_btn,
    input  logic [10:0] xpos_player,
    input  logic [10:0] ypos_player,
    input  logic        hit,
    output logic [10:0] xpos_missile,
    output logic [10:0] ypos_missile,
    output logic        on_missile,
    output logic [7:0]  shots
);

    // One counter serves as the move divider in FLY and the cooldown timer in
    // COOL; the two phases never overlap.
    localparam int unsigned CNT_MAX = (MOVE_DIV > COOLDOWN) ? MOVE_DIV : COOLDOWN;
    localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_DIV - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);

    localparam logic [11:0] X_OFFSET   = 12'(SHIP_W / 2 - MISSILE_W / 2);
    localparam logic [11:0] X_LIMIT    = 12'(X_MAX - MISSILE_W + 1);
    localparam logic [10:0] Y_LAUNCH   = 11'(Y_TOP + MISSILE_H);
    localparam logic [10:0] Y_MOVE_MIN = 11'(Y_TOP + STEP);
    localparam logic [10:0] STEP_PX    = 11'(STEP);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [10:0]   x_q,     x_d;
    logic [10:0]   y_q,     y_d;
    logic          on_q,    on_d;
    logic [7:0]    shots_q, shots_d;

    logic          fire_pulse;
    logic [11:0]   x_sum;
    logic [10:0]   launch_x;
    logic [10:0]   launch_y;

    sync_edge u_fire_sync (
        .pclk    (pclk),
        .rst     (rst),
        .d_async (fire_btn),
        .pulse   (fire_pulse)
    );

    // Centre the missile on the ship nose; 12-bit sum so a far-right ship
    // cannot wrap before the clamp.
    assign x_sum    = {1'b0, xpos_player} + X_OFFSET;
    assign launch_x = (x_sum > X_LIMIT) ? X_LIMIT[10:0] : x_sum[10:0];
    assign launch_y = (ypos_player < Y_LAUNCH) ? 11'(Y_TOP)
                                               : (ypos_player - 11'(MISSILE_H));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            on_q    <= 1'b0;
            shots_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            on_q    <= on_d;
            shots_q <= shots_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        on_d    = on_q;
        shots_d = shots_q;

        case (state_q)
            IDLE: begin
                if (fire_pulse) begin
                    state_d = FLY;
                    x_d     = launch_x;
                    y_d     = launch_y;
                    on_d    = 1'b1;
                    shots_d = shots_q + 8'd1;
                    cnt_d   = '0;
                end
            end

            FLY: begin
                // A hit outranks a coincident move step.
                if (hit) begin
                    state_d = COOL;
                    on_d    = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == MOVE_LAST) begin
                    cnt_d = '0;
                    if (y_q >= Y_MOVE_MIN) begin
                        y_d = y_q - STEP_PX;
                    end else begin
                        state_d = COOL;
                        on_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            COOL: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                on_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign xpos_missile = x_q;
    assign ypos_missile = y_q;
    assign on_missile   = on_q;
    assign shots        = shots_q;

endmodule : ctl_missile_player

// File: tb/tb_ctl_missile_player.sv
module tb_ctl_missile_player;

    logic        pclk;
    logic        rst;
    logic        fire_btn;
    logic [10:0] xpos_player;
    logic [10:0] ypos_player;
    logic        hit;
    logic [10:0] xpos_missile;
    logic [10:0] ypos_missile;
    logic        on_missile;
    logic [7:0]  shots;

    int n_vec = 0;
    int n_err = 0;

    ctl_missile_player #(
        .MOVE_DIV (4),
        .STEP     (4),
        .COOLDOWN (8)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .fire_btn     (fire_btn),
        .xpos_player  (xpos_player),
        .ypos_player  (ypos_player),
        .hit          (hit),
        .xpos_missile (xpos_missile),
        .ypos_missile (ypos_missile),
        .on_missile   (on_missile),
        .shots        (shots)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct {
        logic [10:0] xp;
        logic [10:0] yp;
        logic [10:0] ex;    // launch x
        logic [10:0] ey;    // launch y
        logic [10:0] ey4;   // y after the first move step
        logic        eon4;  // alive after the first move step
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Called at a negedge: asserts rst between edges, checks the outputs
    // cleared asynchronously, releases on the following negedge.
    task automatic do_reset();
        fire_btn = 1'b0;
        hit      = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_on",    on_missile,   0);
        chk("rst_x",     xpos_missile, 0);
        chk("rst_y",     ypos_missile, 0);
        chk("rst_shots", shots,        0);
        @(negedge pclk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        fire_btn    = 1'b0;
        hit         = 1'b0;
        xpos_player = '0;
        ypos_player = '0;

        tbl[0] = '{xp: 11'd480,  yp: 11'd700, ex: 11'd510,  ey: 11'd684, ey4: 11'd680, eon4: 1'b1};
        tbl[1] = '{xp: 11'd1000, yp: 11'd5,   ex: 11'd1020, ey: 11'd0,   ey4: 11'd0,   eon4: 1'b0};
        tbl[2] = '{xp: 11'd0,    yp: 11'd24,  ex: 11'd30,   ey: 11'd8,   ey4: 11'd4,   eon4: 1'b1};
        tbl[3] = '{xp: 11'd993,  yp: 11'd16,  ex: 11'd1020, ey: 11'd0,   ey4: 11'd0,   eon4: 1'b0};
        tbl[4] = '{xp: 11'd990,  yp: 11'd17,  ex: 11'd1020, ey: 11'd1,   ey4: 11'd1,   eon4: 1'b0};
        tbl[5] = '{xp: 11'd100,  yp: 11'd20,  ex: 11'd130,  ey: 11'd4,   ey4: 11'd0,   eon4: 1'b1};

        #1;
        chk("init_on",    on_missile,   0);
        chk("init_x",     xpos_missile, 0);
        chk("init_y",     ypos_missile, 0);
        chk("init_shots", shots,        0);
        @(negedge pclk);
        rst = 1'b0;
        step(2);

        // Launch geometry, latency and first move step; each vector starts
        // from a reset applied while the previous missile is still in flight.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            xpos_player = tbl[i].xp;
            ypos_player = tbl[i].yp;
            step(1);
            fire_btn = 1'b1;
            step(2);
            chk("lat_on_early", on_missile, 0);
            step(1);
            chk("launch_on",    on_missile,   1);
            chk("launch_x",     xpos_missile, tbl[i].ex);
            chk("launch_y",     ypos_missile, tbl[i].ey);
            chk("launch_shots", shots,        1);
            step(4);
            chk("move1_y",  ypos_missile, tbl[i].ey4);
            chk("move1_on", on_missile,   tbl[i].eon4);
            chk("move1_x",  xpos_missile, tbl[i].ex);
        end

        // Second move step, and player motion must not steer the missile.
        do_reset();
        xpos_player = 11'd480;
        ypos_player = 11'd700;
        step(1);
        fire_btn = 1'b1;
        step(3);
        chk("s1_y0", ypos_missile, 684);
        xpos_player = 11'd200;
        ypos_player = 11'd300;
        step(4);
        chk("s1_y1", ypos_missile, 680);
        step(4);
        chk("s1_y2", ypos_missile, 676);
        chk("s1_x",  xpos_missile, 510);

        // Top of screen, then a fire edge on the COOL->IDLE cycle is dropped.
        do_reset();
        xpos_player = 11'd0;
        ypos_player = 11'd24;
        step(1);
        fire_btn = 1'b1;
        step(3);
        chk("top_y8", ypos_missile, 8);
        step(4);
        chk("top_y4", ypos_missile, 4);
        step(4);
        chk("top_y0",  ypos_missile, 0);
        chk("top_on0", on_missile,   1);
        step(4);
        chk("top_retire_on", on_missile,   0);
        chk("top_retire_y",  ypos_missile, 0);
        fire_btn = 1'b0;
        step(5);
        fire_btn = 1'b1;
        step(3);
        chk("cool_edge_on", on_missile, 0);
        step(2);
        chk("cool_edge_on2",   on_missile, 0);
        chk("cool_edge_shots", shots,      1);
        fire_btn = 1'b0;
        step(3);
        fire_btn = 1'b1;
        step(3);
        chk("rearm_on",    on_missile, 1);
        chk("rearm_shots", shots,      2);

        // Hit mid-flight, then first accepted edge right after cooldown,
        // then a hit coinciding with a move step.
        do_reset();
        xpos_player = 11'd480;
        ypos_player = 11'd700;
        step(1);
        fire_btn = 1'b1;
        step(3);
        fire_btn = 1'b0;
        step(2);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk("hit_on", on_missile,   0);
        chk("hit_y",  ypos_missile, 684);
        chk("hit_x",  xpos_missile, 510);
        step(6);
        fire_btn = 1'b1;
        step(2);
        chk("cool_len_on0", on_missile, 0);
        step(1);
        chk("cool_len_on1",  on_missile,   1);
        chk("cool_len_shot", shots,        2);
        chk("cool_len_y",    ypos_missile, 684);
        step(3);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk("hitmove_on", on_missile,   0);
        chk("hitmove_y",  ypos_missile, 684);

        // Fire held through a flight, then toggles in FLY and COOL.
        do_reset();
        xpos_player = 11'd0;
        ypos_player = 11'd24;
        step(1);
        fire_btn = 1'b1;
        step(3);
        chk("hold_shots0", shots, 1);
        step(30);
        chk("hold_shots", shots,      1);
        chk("hold_on",    on_missile, 0);
        ypos_player = 11'd700;
        fire_btn = 1'b0;
        step(2);
        fire_btn = 1'b1;
        step(3);
        chk("edge2_on",    on_missile, 1);
        chk("edge2_shots", shots,      2);
        fire_btn = 1'b0;
        step(2);
        fire_btn = 1'b1;
        step(3);
        chk("flytog_shots", shots,        2);
        chk("flytog_on",    on_missile,   1);
        chk("flytog_y",     ypos_missile, 680);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk("d_hit_on", on_missile, 0);
        fire_btn = 1'b0;
        step(2);
        fire_btn = 1'b1;
        step(3);
        chk("cooltog_shots", shots,      2);
        chk("cooltog_on",    on_missile, 0);
        step(10);
        chk("idle_noedge_on",    on_missile, 0);
        chk("idle_noedge_shots", shots,      2);

        // Reset mid-flight, then immediate relaunch with no cooldown.
        do_reset();
        xpos_player = 11'd480;
        ypos_player = 11'd700;
        step(1);
        fire_btn = 1'b1;
        step(3);
        chk("e_on", on_missile, 1);
        step(2);
        do_reset();
        step(1);
        fire_btn = 1'b1;
        step(3);
        chk("post_rst_on",    on_missile,   1);
        chk("post_rst_shots", shots,        1);
        chk("post_rst_x",     xpos_missile, 510);
        chk("post_rst_y",     ypos_missile, 684);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ctl_missile_player
